// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS timer control front end.
// Digit indices follow the sel encoding; maxima bound each BCD preset digit.
package timer_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEL_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_RUN,
    ST_PAUSE,
    ST_ALARM
  } state_e;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] preset_t;

  localparam logic [SEL_W-1:0] DIG_M10 = 2'd0;
  localparam logic [SEL_W-1:0] DIG_M1  = 2'd1;
  localparam logic [SEL_W-1:0] DIG_S10 = 2'd2;
  localparam logic [SEL_W-1:0] DIG_S1  = 2'd3;

  localparam bcd_t MAX_M10 = 4'd9;
  localparam bcd_t MAX_M1  = 4'd9;
  localparam bcd_t MAX_S10 = 4'd5;
  localparam bcd_t MAX_S1  = 4'd9;

  function automatic bcd_t digit_max(input logic [SEL_W-1:0] idx);
    case (idx)
      DIG_M10: digit_max = MAX_M10;
      DIG_M1:  digit_max = MAX_M1;
      DIG_S10: digit_max = MAX_S10;
      default: digit_max = MAX_S1;
    endcase
  endfunction

  // Wrap to zero at the digit's maximum; anything at or above max also wraps.
  function automatic bcd_t digit_inc(input logic [SEL_W-1:0] idx, input bcd_t d);
    if (d >= digit_max(idx)) digit_inc = '0;
    else                     digit_inc = d + 4'd1;
  endfunction

endpackage

// File: rtl/timer_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level followed by a
// rising-edge detector producing a one-cycle event.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_c
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = async_i;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = s2_q & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Control front end for the MM:SS down counter: preset editing, load strobe,
// 1 Hz count strobe, zero watch and timed alarm.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned ALARM_CYCLES = 3000,
  parameter int unsigned ZERO_BLANK   = 3
) (
  input  logic             c1khz,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_set,
  input  logic             btn_next,
  input  logic             btn_inc,
  input  logic             btn_clr,
  input  logic             zero,
  output logic [3:0]       pm10,
  output logic [3:0]       pm1,
  output logic [3:0]       ps10,
  output logic [3:0]       ps1,
  output logic             load,
  output logic             count,
  output logic [1:0]       sel,
  output logic             editing,
  output logic             running,
  output logic             alarm
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned ALARM_W = $clog2(ALARM_CYCLES);
  localparam int unsigned BLANK_W = $clog2(ZERO_BLANK + 2);

  logic ev_start_c, ev_set_c, ev_next_c, ev_inc_c, ev_clr_c;

  btn_sync_edge u_sync_start (.clk(c1khz), .rst_n(rst), .async_i(btn_start), .rise_c(ev_start_c));
  btn_sync_edge u_sync_set   (.clk(c1khz), .rst_n(rst), .async_i(btn_set),   .rise_c(ev_set_c));
  btn_sync_edge u_sync_next  (.clk(c1khz), .rst_n(rst), .async_i(btn_next),  .rise_c(ev_next_c));
  btn_sync_edge u_sync_inc   (.clk(c1khz), .rst_n(rst), .async_i(btn_inc),   .rise_c(ev_inc_c));
  btn_sync_edge u_sync_clr   (.clk(c1khz), .rst_n(rst), .async_i(btn_clr),   .rise_c(ev_clr_c));

  // zero is a level flag, so it is synchronized without edge detection
  logic zero_s1_q, zero_s1_d;
  logic zero_s2_q, zero_s2_d;

  state_e                 state_q, state_d;
  preset_t                digits_q, digits_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [ALARM_W-1:0]     atmr_q, atmr_d;
  logic [BLANK_W-1:0]     blank_q, blank_d;
  logic                   load_q, load_d;
  logic                   count_q, count_d;
  logic                   editing_q, editing_d;
  logic                   running_q, running_d;
  logic                   alarm_q, alarm_d;
  logic                   launch;
  logic                   preset_nz;

  assign preset_nz = |digits_q;

  always_comb begin
    zero_s1_d = zero;
    zero_s2_d = zero_s1_q;

    state_d  = state_q;
    digits_d = digits_q;
    sel_d    = sel_q;
    presc_d  = presc_q;
    atmr_d   = atmr_q;
    blank_d  = blank_q;
    load_d   = 1'b0;
    count_d  = 1'b0;
    launch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev_start_c) begin
          launch = preset_nz;
        end else if (ev_set_c) begin
          state_d = ST_SET;
          sel_d   = DIG_M10;
        end
      end
      ST_SET: begin
        if (ev_start_c) begin
          launch = preset_nz;
        end else if (ev_set_c) begin
          state_d = ST_IDLE;
        end else if (ev_next_c) begin
          sel_d = sel_q + SEL_W'(1);
        end else if (ev_inc_c) begin
          digits_d[sel_q] = digit_inc(sel_q, digits_q[sel_q]);
        end
      end
      ST_RUN: begin
        if (blank_q != '0) blank_d = blank_q - BLANK_W'(1);
        if (zero_s2_q && (blank_q == '0)) begin
          state_d = ST_ALARM;
          atmr_d  = '0;
        end else if (ev_start_c) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
          presc_d = '0;
          count_d = 1'b1;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      ST_PAUSE: begin
        if (ev_start_c)    state_d = ST_RUN;
        else if (ev_clr_c) state_d = ST_IDLE;
      end
      ST_ALARM: begin
        if (ev_clr_c || (atmr_q == ALARM_W'(ALARM_CYCLES - 1))) state_d = ST_IDLE;
        else                                                     atmr_d  = atmr_q + ALARM_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A new run always restarts the prescaler and the zero blanking window
    if (launch) begin
      state_d = ST_RUN;
      load_d  = 1'b1;
      presc_d = '0;
      blank_d = BLANK_W'(ZERO_BLANK);
    end

    editing_d = (state_d == ST_SET);
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge c1khz or negedge rst) begin
    if (!rst) begin
      zero_s1_q <= 1'b0;
      zero_s2_q <= 1'b0;
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      sel_q     <= '0;
      presc_q   <= '0;
      atmr_q    <= '0;
      blank_q   <= '0;
      load_q    <= 1'b0;
      count_q   <= 1'b0;
      editing_q <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      zero_s1_q <= zero_s1_d;
      zero_s2_q <= zero_s2_d;
      state_q   <= state_d;
      digits_q  <= digits_d;
      sel_q     <= sel_d;
      presc_q   <= presc_d;
      atmr_q    <= atmr_d;
      blank_q   <= blank_d;
      load_q    <= load_d;
      count_q   <= count_d;
      editing_q <= editing_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign pm10    = digits_q[DIG_M10];
  assign pm1     = digits_q[DIG_M1];
  assign ps10    = digits_q[DIG_S10];
  assign ps1     = digits_q[DIG_S1];
  assign sel     = sel_q;
  assign load    = load_q;
  assign count   = count_q;
  assign editing = editing_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed button/zero stimulus, a per-cycle behavioural
// model compared on every falling edge, plus hand-computed timing checks.
module tb_timer_ctrl;

  localparam int TICK  = 1000;
  localparam int ACYC  = 3000;
  localparam int BLANK = 3;

  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_SET   = 5'b00010;
  localparam logic [4:0] B_NEXT  = 5'b00100;
  localparam logic [4:0] B_INC   = 5'b01000;
  localparam logic [4:0] B_CLR   = 5'b10000;

  localparam int MI = 0, MS = 1, MR = 2, MP = 3, MA = 4;

  logic c1khz = 1'b0;
  logic rst = 1'b0;
  logic btn_start = 1'b0, btn_set = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0;
  logic zero = 1'b0;
  logic [3:0] pm10, pm1, ps10, ps1;
  logic load, count, editing, running, alarm;
  logic [1:0] sel;

  int n_cmp = 0;
  int n_err = 0;

  timer_ctrl dut (
    .c1khz(c1khz), .rst(rst),
    .btn_start(btn_start), .btn_set(btn_set), .btn_next(btn_next),
    .btn_inc(btn_inc), .btn_clr(btn_clr), .zero(zero),
    .pm10(pm10), .pm1(pm1), .ps10(ps10), .ps1(ps1),
    .load(load), .count(count), .sel(sel),
    .editing(editing), .running(running), .alarm(alarm)
  );

  always #5 c1khz = ~c1khz;

  // Behavioural model: inputs seen at edge k act on the FSM two edges later.
  int m_mode, m_sel, m_presc, m_blank, m_atm;
  int m_dig[4];
  bit m_load, m_count;
  bit hist[6][3];
  int maxv[4] = '{9, 9, 5, 9};

  task automatic model_reset();
    m_mode = MI; m_sel = 0; m_presc = 0; m_blank = 0; m_atm = 0;
    m_load = 0; m_count = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 3; j++) hist[i][j] = 0;
  endtask

  task automatic model_step();
    bit cur[6];
    bit ev[6];
    bit zs;
    int old_blank;
    int total;
    if (!rst) begin
      model_reset();
      return;
    end
    cur = '{btn_start, btn_set, btn_next, btn_inc, btn_clr, zero};
    zs = hist[5][1];
    for (int i = 0; i < 6; i++) begin
      ev[i] = hist[i][1] && !hist[i][2];
      hist[i][2] = hist[i][1];
      hist[i][1] = hist[i][0];
      hist[i][0] = cur[i];
    end
    total = m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3];
    m_load = 0;
    m_count = 0;
    if ((m_mode == MI || m_mode == MS) && ev[0]) begin
      if (total > 0) begin
        m_mode = MR; m_load = 1; m_presc = 0; m_blank = BLANK;
      end
    end else if (m_mode == MI) begin
      if (ev[1]) begin m_mode = MS; m_sel = 0; end
    end else if (m_mode == MS) begin
      if (ev[1])      m_mode = MI;
      else if (ev[2]) m_sel = (m_sel + 1) % 4;
      else if (ev[3]) m_dig[m_sel] = (m_dig[m_sel] + 1) % (maxv[m_sel] + 1);
    end else if (m_mode == MR) begin
      old_blank = m_blank;
      if (m_blank > 0) m_blank--;
      if (zs && old_blank == 0) begin
        m_mode = MA; m_atm = 0;
      end else if (ev[0]) begin
        m_mode = MP;
      end else begin
        m_presc++;
        if (m_presc == TICK) begin m_presc = 0; m_count = 1; end
      end
    end else if (m_mode == MP) begin
      if (ev[0])      m_mode = MR;
      else if (ev[4]) m_mode = MI;
    end else if (m_mode == MA) begin
      m_atm++;
      if (ev[4] || m_atm == ACYC) m_mode = MI;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("pm10", int'(pm10), m_dig[0]);
    chk("pm1", int'(pm1), m_dig[1]);
    chk("ps10", int'(ps10), m_dig[2]);
    chk("ps1", int'(ps1), m_dig[3]);
    chk("sel", int'(sel), m_sel);
    chk("load", int'(load), int'(m_load));
    chk("count", int'(count), int'(m_count));
    chk("editing", int'(editing), int'(m_mode == MS));
    chk("running", int'(running), int'(m_mode == MR));
    chk("alarm", int'(alarm), int'(m_mode == MA));
    chk("load_count_exclusive", int'(load & count), 0);
  endtask

  task automatic step();
    @(posedge c1khz);
    model_step();
    @(negedge c1khz);
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic [4:0] m);
    btn_start = m[0]; btn_set = m[1]; btn_next = m[2]; btn_inc = m[3]; btn_clr = m[4];
    step();
    btn_start = 1'b0; btn_set = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0;
  endtask

  task automatic press(input logic [4:0] m);
    pulse(m);
    steps(4);
  endtask

  function automatic bit sig(input int w);
    case (w)
      0:       return load;
      1:       return count;
      2:       return alarm;
      default: return !alarm;
    endcase
  endfunction

  // Steps until the selected output is seen; n == budget means it never came.
  task automatic wait_for(input int w, input int budget, output int n);
    n = 0;
    while (!sig(w) && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    model_reset();
    steps(3);
    chk("reset_digits", int'({pm10, pm1, ps10, ps1}), 0);
    chk("reset_strobes", int'({load, count, alarm, editing, running}), 0);
    rst = 1'b1;
    steps(2);

    pulse(B_START);
    wait_for(0, 10, n);
    chk("start_at_0000_ignored", n, 10);

    // Preset editing, including digit wrap-around
    press(B_SET);
    chk("editing_after_set", int'(editing), 1);
    repeat (3) press(B_NEXT);
    chk("sel_after_3_next", int'(sel), 3);
    repeat (3) press(B_INC);
    chk("ps1_after_3_inc", int'(ps1), 3);
    repeat (3) press(B_NEXT);
    chk("sel_wraps_to_2", int'(sel), 2);
    repeat (7) press(B_INC);
    chk("ps10_wrap_5_to_0", int'(ps10), 1);
    repeat (2) press(B_NEXT);
    chk("sel_at_0", int'(sel), 0);
    repeat (9) press(B_INC);
    chk("pm10_at_9", int'(pm10), 9);
    press(B_INC);
    chk("pm10_wrap_9_to_0", int'(pm10), 0);
    repeat (2) press(B_NEXT);
    repeat (5) press(B_INC);
    chk("ps10_back_to_0", int'(ps10), 0);
    press(B_NEXT);
    repeat (2) press(B_INC);
    chk("preset_0005", int'({pm10, pm1, ps10, ps1}), 16'h0005);
    press(B_SET);
    chk("editing_left", int'(editing), 0);

    // Run: load strobe and 1 Hz count cadence
    pulse(B_START);
    wait_for(0, 10, n);
    chk("load_latency", n, 2);
    chk("running_at_load", int'(running), 1);
    wait_for(1, 1100, n);
    chk("first_count_after_load", n, 1000);
    step();
    wait_for(1, 1100, n);
    chk("count_period", n + 1, 1000);

    // Pause with the prescaler at 400, then resume
    steps(398);
    pulse(B_START);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      cnt += int'(count);
    end
    chk("no_count_in_pause", cnt, 0);
    chk("running_low_in_pause", int'(running), 0);
    pulse(B_START);
    wait_for(1, 700, n);
    chk("resume_to_count", n, 602);
    repeat (3) begin
      step();
      wait_for(1, 1100, n);
    end
    chk("sixth_count_period", n + 1, 1000);

    // Expiry: alarm timing and preset retention
    zero = 1'b1;
    wait_for(2, 10, n);
    chk("alarm_latency", n, 3);
    chk("count_low_in_alarm", int'(count), 0);
    wait_for(3, 3100, n);
    chk("alarm_duration", n, 3000);
    zero = 1'b0;
    chk("preset_retained", int'({pm10, pm1, ps10, ps1}), 16'h0005);
    chk("running_after_alarm", int'(running), 0);
    steps(3);

    // Asynchronous reset in the middle of a run
    pulse(B_START);
    wait_for(0, 10, n);
    steps(500);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({pm10, pm1, ps10, ps1, sel, load, count, alarm, editing, running}), 0);
    model_reset();
    steps(2);
    rst = 1'b1;
    steps(3);
    chk("idle_after_reset", int'(running), 0);

    // Start and set in the same cycle while editing: start wins
    press(B_SET);
    repeat (3) press(B_NEXT);
    press(B_INC);
    pulse(B_START | B_SET);
    wait_for(0, 10, n);
    chk("start_wins_over_set", n, 2);
    chk("editing_dropped", int'(editing), 0);
    chk("running_after_start", int'(running), 1);

    // Clear is ignored in RUN, aborts from PAUSE
    steps(50);
    press(B_CLR);
    chk("clr_ignored_in_run", int'(running), 1);
    press(B_START);
    press(B_CLR);
    chk("clr_from_pause", int'({running, editing, alarm}), 0);

    // Zero already high at load: blanking window, then clear from ALARM
    zero = 1'b1;
    steps(4);
    pulse(B_START);
    wait_for(0, 10, n);
    wait_for(2, 10, n);
    chk("zero_blank_window", n, 4);
    pulse(B_CLR);
    wait_for(3, 10, n);
    chk("alarm_clr", n, 2);
    zero = 1'b0;
    steps(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
